mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared memory-interface definitions: responder FSM encoding,
// default timing/geometry and the constants the cache also relies on.
package mem_responder_pkg;

  localparam int DEF_LATENCY = 4;
  localparam int DEF_AW      = 12;
  localparam int CNT_W       = 4;

  localparam int WORD_BYTES  = 4;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_OFF_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a memory client (master) and the
// responder (slave): ready, addr, ren, wen, wdata, rdata, valid.
interface mem_responder_if;

  logic        o_mem_ready;
  logic [31:0] i_mem_addr;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_valid;

  modport master (
    input  o_mem_ready,
    input  o_mem_rdata,
    input  o_mem_valid,
    output i_mem_addr,
    output i_mem_ren,
    output i_mem_wen,
    output i_mem_wdata
  );

  modport slave (
    output o_mem_ready,
    output o_mem_rdata,
    output o_mem_valid,
    input  i_mem_addr,
    input  i_mem_ren,
    input  i_mem_wen,
    input  i_mem_wdata
  );

endinterface

// File: rtl/mem_array.sv
// 2**AW x 32 storage: one synchronous write port, combinational read.
// Ports: clk, we, addr (word index), wdata, rdata. Not reset.
module mem_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-outstanding memory responder.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave side).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int AW      = DEF_AW
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [AW-1:0]    addr_q;
  logic             wr_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic             in_resp;
  logic             arr_we;
  logic [31:0]      arr_rdata;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.i_mem_addr[31:AW+2],
                              bus.i_mem_addr[1:0]};

  assign accept = (state == IDLE) &&
                  (bus.i_mem_ren || bus.i_mem_wen);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // wen wins when both strobes are high
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q  <= bus.i_mem_addr[AW+1:2];
      wr_q    <= bus.i_mem_wen;
      wdata_q <= bus.i_mem_wdata;
    end
  end

  // counter holds LATENCY-1 on entry to WAIT; leaving when the
  // decremented value hits 0 lands RESP exactly LATENCY cycles later
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_ONE) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // reset asserted in RESP kills both the strobe and the write
  assign in_resp = (state == RESP) && i_rst_n;
  assign arr_we  = in_resp && wr_q;

  mem_array #(
    .AW (AW)
  ) u_array (
    .clk   (i_clk),
    .we    (arr_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign bus.o_mem_ready = (state == IDLE);
  assign bus.o_mem_valid = in_resp && !wr_q;
  assign bus.o_mem_rdata = (in_resp && !wr_q) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=4 and LATENCY=1 instances
// checked cycle by cycle with immediate assertions.
module tb_mem_responder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.LATENCY(4), .AW(12)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a.slave)
  );

  mem_responder #(.LATENCY(1), .AW(12)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit sel, bit rd, bit wr,
                       logic [31:0] addr, logic [31:0] wdata);
    if (sel) begin
      bus_b.i_mem_ren   = rd;
      bus_b.i_mem_wen   = wr;
      bus_b.i_mem_addr  = addr;
      bus_b.i_mem_wdata = wdata;
    end else begin
      bus_a.i_mem_ren   = rd;
      bus_a.i_mem_wen   = wr;
      bus_a.i_mem_addr  = addr;
      bus_a.i_mem_wdata = wdata;
    end
  endtask

  task automatic sample(bit sel, output logic rdy,
                        output logic vld, output logic [31:0] rd);
    if (sel) begin
      rdy = bus_b.o_mem_ready;
      vld = bus_b.o_mem_valid;
      rd  = bus_b.o_mem_rdata;
    end else begin
      rdy = bus_a.o_mem_ready;
      vld = bus_a.o_mem_valid;
      rd  = bus_a.o_mem_rdata;
    end
  endtask

  // one full transaction from acceptance to ready's return
  task automatic txn(string tag, bit sel, int lat, bit rd, bit wr,
                     logic [31:0] addr, logic [31:0] wdata,
                     bit exp_vld, logic [31:0] exp_data);
    logic rdy;
    logic vld;
    logic [31:0] rdat;
    drive(sel, rd, wr, addr, wdata);
    sample(sel, rdy, vld, rdat);
    chk({tag, "_acc_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_acc_valid"}, 32'(vld), 32'd0);
    tick();
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= lat; c++) begin
      sample(sel, rdy, vld, rdat);
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(rdy), 32'd0);
      if (c == lat) begin
        chk($sformatf("%s_valid_c%0d", tag, c), 32'(vld), 32'(exp_vld));
        chk($sformatf("%s_rdata_c%0d", tag, c), rdat,
            exp_vld ? exp_data : 32'h0);
      end else begin
        chk($sformatf("%s_valid_c%0d", tag, c), 32'(vld), 32'd0);
        chk($sformatf("%s_rdata_c%0d", tag, c), rdat, 32'h0);
      end
      tick();
    end
    sample(sel, rdy, vld, rdat);
    chk({tag, "_end_ready"}, 32'(rdy), 32'd1);
    chk({tag, "_end_valid"}, 32'(vld), 32'd0);
    chk({tag, "_end_rdata"}, rdat, 32'h0);
  endtask

  initial begin
    logic rdy;
    logic vld;
    logic [31:0] rdat;
    logic [31:0] burst_data [4];
    burst_data[0] = 32'h1111_0000;
    burst_data[1] = 32'h2222_1111;
    burst_data[2] = 32'h3333_2222;
    burst_data[3] = 32'h4444_3333;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    sample(1'b0, rdy, vld, rdat);
    chk("rst_a_ready", 32'(rdy), 32'd1);
    chk("rst_a_valid", 32'(vld), 32'd0);
    chk("rst_a_rdata", rdat, 32'h0);
    sample(1'b1, rdy, vld, rdat);
    chk("rst_b_ready", 32'(rdy), 32'd1);
    chk("rst_b_valid", 32'(vld), 32'd0);

    // write then read-after-write at 0x40
    txn("wr40", 1'b0, 4, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0);
    txn("rd40", 1'b0, 4, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // preload and burst-read four words
    for (int i = 0; i < 4; i++)
      txn($sformatf("bwr%0d", i), 1'b0, 4, 1'b0, 1'b1,
          32'h100 + 32'(4 * i), burst_data[i], 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      txn($sformatf("brd%0d", i), 1'b0, 4, 1'b1, 1'b0,
          32'h100 + 32'(4 * i), 32'h0, 1'b1, burst_data[i]);

    // request raised during WAIT must be dropped
    txn("wr200", 1'b0, 4, 1'b0, 1'b1, 32'h200, 32'h5A5A_5A5A, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      sample(1'b0, rdy, vld, rdat);
      chk($sformatf("ign_ready_c%0d", c), 32'(rdy), (c >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("ign_valid_c%0d", c), 32'(vld), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ign_rdata_c%0d", c), rdat,
          (c == 4) ? 32'hDEAD_BEEF : 32'h0);
      tick();
    end

    // reset in write RESP aborts the write
    txn("wr80", 1'b0, 4, 1'b0, 1'b1, 32'h80, 32'hAAAA_5555, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    sample(1'b0, rdy, vld, rdat);
    chk("abort_resp_ready", 32'(rdy), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sample(1'b0, rdy, vld, rdat);
    chk("abort_post_ready", 32'(rdy), 32'd1);
    chk("abort_post_valid", 32'(vld), 32'd0);
    chk("abort_post_rdata", rdat, 32'h0);
    txn("rd80", 1'b0, 4, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'hAAAA_5555);

    // LATENCY=1: aliasing and illegal ren+wen treated as write
    txn("b_wr4004", 1'b1, 1, 1'b0, 1'b1, 32'h4004, 32'hCAFE_F00D, 1'b0, 32'h0);
    txn("b_rd4004", 1'b1, 1, 1'b1, 1'b0, 32'h4004, 32'h0, 1'b1, 32'hCAFE_F00D);
    txn("b_rd0004", 1'b1, 1, 1'b1, 1'b0, 32'h0004, 32'h0, 1'b1, 32'hCAFE_F00D);
    txn("b_both8",  1'b1, 1, 1'b1, 1'b1, 32'h8, 32'h0BAD_F00D, 1'b0, 32'h0);
    txn("b_rd8",    1'b1, 1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
